// File: rtl/mem_access_unit.sv
// Load/store unit: one outstanding word-bus access per operation,
// with lane steering on stores and align/extend on loads.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic              mem_op,
  input  logic [1:0]        access_size,
  input  logic              read_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [DATA_W-1:0] result_data,
  output logic              result_err
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  state_t state, state_n;

  logic [1:0]        size_q, size_n;
  logic              uns_q, uns_n;
  logic [1:0]        off_q, off_n;
  logic              req_n, we_n, rv_n, err_n;
  logic [ADDR_W-1:0] baddr_n;
  logic [3:0]        be_n;
  logic [DATA_W-1:0] wdata_n, rdata_n;

  logic              bad;
  logic [3:0]        be_c;
  logic [DATA_W-1:0] wd_c;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] ext;

  assign issue_ready = (state == IDLE);

  always_comb begin
    bad  = 1'b0;
    be_c = 4'b0000;
    wd_c = '0;
    unique case (access_size)
      2'b00: begin
        be_c = 4'b0001 << addr[1:0];
        wd_c = {4{store_data[7:0]}};
      end
      2'b01: begin
        bad  = addr[0];
        be_c = 4'b0011 << addr[1:0];
        wd_c = {2{store_data[15:0]}};
      end
      2'b10: begin
        bad  = (addr[1:0] != 2'b00);
        be_c = 4'b1111;
        wd_c = store_data;
      end
      default: bad = 1'b1;
    endcase
  end

  // Load alignment uses the offset captured at issue time.
  always_comb begin
    sh  = bus_rdata >> {off_q, 3'b000};
    ext = bus_rdata;
    unique case (size_q)
      2'b00: ext = uns_q ? {24'h0, sh[7:0]}
                         : {{24{sh[7]}}, sh[7:0]};
      2'b01: ext = uns_q ? {16'h0, sh[15:0]}
                         : {{16{sh[15]}}, sh[15:0]};
      default: ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_n = state;
    size_n  = size_q;
    uns_n   = uns_q;
    off_n   = off_q;
    req_n   = bus_req;
    we_n    = bus_we;
    baddr_n = bus_addr;
    be_n    = bus_be;
    wdata_n = bus_wdata;
    rv_n    = result_valid;
    err_n   = result_err;
    rdata_n = result_data;
    unique case (state)
      IDLE: begin
        if (issue_valid) begin
          size_n  = access_size;
          uns_n   = read_unsigned;
          off_n   = addr[1:0];
          rdata_n = '0;
          if (bad) begin
            state_n = RESP;
            rv_n    = 1'b1;
            err_n   = 1'b1;
          end else begin
            state_n = BUS;
            err_n   = 1'b0;
            req_n   = 1'b1;
            we_n    = !mem_op;
            baddr_n = {addr[ADDR_W-1:2], 2'b00};
            be_n    = be_c;
            wdata_n = mem_op ? '0 : wd_c;
          end
        end
      end
      BUS: begin
        if (bus_ack) begin
          state_n = RESP;
          req_n   = 1'b0;
          rv_n    = 1'b1;
          rdata_n = bus_we ? '0 : ext;
        end
      end
      RESP: begin
        if (result_ready) begin
          state_n = IDLE;
          rv_n    = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_be       <= 4'b0000;
      bus_wdata    <= '0;
      result_valid <= 1'b0;
      result_err   <= 1'b0;
      result_data  <= '0;
    end else begin
      state        <= state_n;
      size_q       <= size_n;
      uns_q        <= uns_n;
      off_q        <= off_n;
      bus_req      <= req_n;
      bus_we       <= we_n;
      bus_addr     <= baddr_n;
      bus_be       <= be_n;
      bus_wdata    <= wdata_n;
      result_valid <= rv_n;
      result_err   <= err_n;
      result_data  <= rdata_n;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; completions checked
// against a queue of expected results by a separate monitor.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        issue_valid;
  logic        issue_ready;
  logic        mem_op;
  logic [1:0]  access_size;
  logic        read_unsigned;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result_data;
  logic        result_err;

  int passed = 0;
  int total  = 0;
  logic [32:0] res_q[$];

  mem_access_unit dut (
    .clk(clk),
    .reset_n(reset_n),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .mem_op(mem_op),
    .access_size(access_size),
    .read_unsigned(read_unsigned),
    .addr(addr),
    .store_data(store_data),
    .bus_req(bus_req),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_be(bus_be),
    .bus_wdata(bus_wdata),
    .bus_ack(bus_ack),
    .bus_rdata(bus_rdata),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_data(result_data),
    .result_err(result_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h", nm, act, exp);
    else
      passed++;
  endtask

  always @(negedge clk) begin
    if (reset_n && result_valid && result_ready) begin
      if (res_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = res_q.pop_front();
        chk("result_err", {31'd0, result_err}, {31'd0, e[32]});
        chk("result_data", result_data, e[31:0]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_chk(input string nm,
                         input logic we, input logic [31:0] ba,
                         input logic [3:0] be, input logic [31:0] wd);
    chk({nm, "_req"}, {31'd0, bus_req}, 32'd1);
    chk({nm, "_we"}, {31'd0, bus_we}, {31'd0, we});
    chk({nm, "_addr"}, bus_addr, ba);
    chk({nm, "_be"}, {28'd0, bus_be}, {28'd0, be});
    chk({nm, "_wdata"}, bus_wdata, wd);
    chk({nm, "_iready"}, {31'd0, issue_ready}, 32'd0);
  endtask

  task automatic run_op(
    input string nm,
    input logic op, input logic [1:0] sz, input logic uns,
    input logic [31:0] a, input logic [31:0] sd,
    input logic [31:0] rd, input int ack_wait, input int rdy_wait,
    input logic err, input logic [3:0] ebe,
    input logic [31:0] ewd, input logic [31:0] eres);
    res_q.push_back({err, eres});
    chk({nm, "_ready_idle"}, {31'd0, issue_ready}, 32'd1);
    issue_valid   = 1'b1;
    mem_op        = op;
    access_size   = sz;
    read_unsigned = uns;
    addr          = a;
    store_data    = sd;
    cyc();
    issue_valid = 1'b0;
    addr        = 32'hFFFF_FFFF;
    store_data  = 32'h5555_5555;
    if (err) begin
      chk({nm, "_noreq"}, {31'd0, bus_req}, 32'd0);
      chk({nm, "_rv1"}, {31'd0, result_valid}, 32'd1);
    end else begin
      bus_chk(nm, !op, {a[31:2], 2'b00}, ebe, ewd);
      for (int i = 0; i < ack_wait; i++) begin
        cyc();
        bus_chk({nm, "_hold"}, !op, {a[31:2], 2'b00}, ebe, ewd);
      end
      bus_ack   = 1'b1;
      bus_rdata = rd;
      cyc();
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
      chk({nm, "_req_drop"}, {31'd0, bus_req}, 32'd0);
      chk({nm, "_rv"}, {31'd0, result_valid}, 32'd1);
    end
    for (int i = 0; i < rdy_wait; i++) begin
      cyc();
      chk({nm, "_rv_hold"}, {31'd0, result_valid}, 32'd1);
      chk({nm, "_data_hold"}, result_data, eres);
      chk({nm, "_iready_lo"}, {31'd0, issue_ready}, 32'd0);
    end
    result_ready = 1'b1;
    cyc();
    result_ready = 1'b0;
    chk({nm, "_rv_clr"}, {31'd0, result_valid}, 32'd0);
    chk({nm, "_iready_back"}, {31'd0, issue_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    reset_n       = 1'b0;
    issue_valid   = 1'b0;
    mem_op        = 1'b0;
    access_size   = 2'b00;
    read_unsigned = 1'b0;
    addr          = 32'h0;
    store_data    = 32'h0;
    bus_ack       = 1'b0;
    bus_rdata     = 32'h0;
    result_ready  = 1'b0;
    cyc();
    cyc();
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_rv", {31'd0, result_valid}, 32'd0);
    chk("rst_err", {31'd0, result_err}, 32'd0);
    chk("rst_data", result_data, 32'h0);
    chk("rst_be", {28'd0, bus_be}, 32'd0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    reset_n = 1'b1;
    cyc();
    chk("rst_iready", {31'd0, issue_ready}, 32'd1);

    run_op("lb", 1, 2'b00, 0, 32'h1003, 0, 32'h80FF_1234,
           0, 0, 0, 4'b1000, 32'h0, 32'hFFFF_FF80);
    run_op("lhu", 1, 2'b01, 1, 32'h2002, 0, 32'hBEEF_0000,
           0, 0, 0, 4'b1100, 32'h0, 32'h0000_BEEF);
    run_op("lh", 1, 2'b01, 0, 32'h2002, 0, 32'hBEEF_0000,
           0, 0, 0, 4'b1100, 32'h0, 32'hFFFF_BEEF);
    run_op("lbu", 1, 2'b00, 1, 32'h3001, 0, 32'h0000_9A00,
           0, 0, 0, 4'b0010, 32'h0, 32'h0000_009A);
    run_op("sb", 0, 2'b00, 0, 32'h0001, 32'h1234_56AB, 32'hDEAD_BEEF,
           0, 0, 0, 4'b0010, 32'hABAB_ABAB, 32'h0);
    run_op("sh", 0, 2'b01, 0, 32'h0402, 32'hFFFF_1234, 32'hDEAD_BEEF,
           0, 0, 0, 4'b1100, 32'h1234_1234, 32'h0);
    run_op("sw", 0, 2'b10, 0, 32'h0408, 32'hCAFE_F00D, 32'h0,
           0, 0, 0, 4'b1111, 32'hCAFE_F00D, 32'h0);
    run_op("ew", 1, 2'b10, 0, 32'h0006, 0, 0,
           0, 0, 1, 4'b0000, 32'h0, 32'h0);
    run_op("eh", 0, 2'b01, 0, 32'h0005, 32'h1111, 0,
           0, 0, 1, 4'b0000, 32'h0, 32'h0);
    run_op("er", 1, 2'b11, 0, 32'h0000, 0, 0,
           0, 1, 1, 4'b0000, 32'h0, 32'h0);
    run_op("lw_wait", 1, 2'b10, 0, 32'h0010, 0, 32'h0123_4567,
           3, 2, 0, 4'b1111, 32'h0, 32'h0123_4567);

    issue_valid   = 1'b1;
    mem_op        = 1'b1;
    access_size   = 2'b10;
    read_unsigned = 1'b0;
    addr          = 32'h0020;
    cyc();
    issue_valid = 1'b0;
    chk("rstmid_req", {31'd0, bus_req}, 32'd1);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    chk("rstmid_req_drop", {31'd0, bus_req}, 32'd0);
    chk("rstmid_rv", {31'd0, result_valid}, 32'd0);
    bus_ack   = 1'b1;
    bus_rdata = 32'h7777_7777;
    cyc();
    bus_ack = 1'b0;
    chk("stray_ack_req", {31'd0, bus_req}, 32'd0);
    chk("stray_ack_rv", {31'd0, result_valid}, 32'd0);
    chk("rstmid_iready", {31'd0, issue_ready}, 32'd1);

    run_op("lw_after", 1, 2'b10, 0, 32'h0000, 0, 32'hCAFE_F00D,
           0, 0, 0, 4'b1111, 32'h0, 32'hCAFE_F00D);

    cyc();
    cyc();
    chk("queue_empty", res_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Executes the memory operation described by the decoded memory parameters: op, access_size and read_unsigned.
- Drives a single-outstanding, word-wide data-memory bus request/acknowledge interface.
- Forms byte enables and replicated store data from address and size.
- Aligns and sign/zero-extends load data.
- Sits between the decode stage's memory parameters and the data memory, and returns one completion per accepted operation.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, bus and register data width; fixed at 32, the lane logic is not generic.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  synchronous active-low reset.
- issue_valid  in  1  operation offered.
- issue_ready  out  1  unit can accept; high only in IDLE.
- mem_op  in  1  1 = read (load), 0 = write (store).
- access_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- read_unsigned  in  1  zero-extend loads when 1; ignored for stores and word loads.
- addr  in  ADDR_W  byte address.
- store_data  in  DATA_W  store value; uses the low bits per size.
- bus_req  out  1  bus request; held until bus_ack.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  word-aligned address, {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  DATA_W  lane-replicated store data.
- bus_ack  in  1  request completed this cycle.
- bus_rdata  in  DATA_W  read data; valid when bus_ack is high for a read.
- result_valid  out  1  completion available.
- result_ready  in  1  consumer accepts the completion.
- result_data  out  DATA_W  extended load value; 0 for stores and errors.
- result_err  out  1  misaligned access or reserved size; no bus access was made.

Behaviour:
- States: IDLE, BUS, RESP.
- Reset (reset_n low at a clock edge):
  - Next state is IDLE.
  - bus_req=0, result_valid=0, result_err=0, result_data=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0.
  - issue_ready=1 once reset_n is high.
- Reset mid-transaction abandons the operation. bus_req drops at that edge and no completion is produced. The memory tolerates a withdrawn request.
- IDLE:
  - issue_ready=1.
  - An operation is accepted on issue_valid & issue_ready; all inputs are registered at that edge.
  - The error check uses the registered inputs:
    - size 11 is an error;
    - half with addr[0]=1 is an error;
    - word with addr[1:0]!=0 is an error.
  - On error: go to RESP with result_err=1, result_data=0. bus_req is never asserted.
  - Otherwise go to BUS.
- BUS:
  - bus_req=1; bus_we=!mem_op; bus_addr, bus_be and bus_wdata are stable and registered.
  - Write lanes, with off=addr[1:0]:
    - byte: be=4'b0001<<off, wdata={4{store_data[7:0]}}.
    - half: be=4'b0011<<off, wdata={2{store_data[15:0]}}.
    - word: be=4'b1111, wdata=store_data.
  - For reads: bus_be is the same pattern and bus_wdata=0.
  - On bus_ack, go to RESP. For a read, capture and extend the data:
    - sh = bus_rdata >> (8*off).
    - byte: sign or zero extend sh[7:0].
    - half: sign or zero extend sh[15:0].
    - word: bus_rdata unchanged.
  - For a write, result_data=0.
  - bus_req deasserts the cycle after ack. bus_ack in the same cycle bus_req first rises is legal.
  - bus_ack while not in BUS is ignored.
- RESP:
  - result_valid=1; result_data and result_err are stable until result_valid & result_ready.
  - The handshake edge moves to IDLE and clears result_valid.
  - result_ready high on arrival completes in the first RESP cycle.
- Latency, minimum zero-wait:
  - Accept at edge 0; bus_req high in cycle 1; ack in cycle 1.
  - result_valid in cycle 2; ready in cycle 2; issue_ready high again in cycle 3.
  - Error path: result_valid in cycle 1.
- No pipelining: at most one operation is outstanding. issue_ready=0 in BUS and RESP regardless of issue_valid.
- Outputs are registered; there is no combinational path from bus_ack or result_ready to any output.

Test Plan:
- Byte load, signed: mem_op=1, size=00, read_unsigned=0, addr=0x1003, bus_rdata=0x80FF_1234 with ack in cycle 1.
  -> bus_addr=0x1000, bus_be=4'b1000, then result_data=0xFFFF_FF80, result_err=0.
- Half load, unsigned: size=01, read_unsigned=1, addr=0x2002, bus_rdata=0xBEEF_0000.
  -> bus_be=4'b1100, result_data=0x0000_BEEF. The same access with read_unsigned=0 -> 0xFFFF_BEEF.
- Byte store: mem_op=0, size=00, addr=0x0001, store_data=0x1234_56AB.
  -> bus_we=1, bus_be=4'b0010, bus_wdata=0xABAB_ABAB, result_data=0.
- Misaligned and reserved: word at addr=0x0006, half at 0x0005, size=11 at 0x0000.
  -> bus_req never rises; result_valid in cycle 1 with result_err=1.
- Wait states and backpressure: bus_ack delayed 3 cycles, result_ready low 2 cycles.
  -> bus_req and bus signals held stable for 4 cycles; result held 3 cycles; issue_ready low throughout.
- Reset mid-BUS: reset_n low while bus_req=1.
  -> next edge bus_req=0, state IDLE, no result_valid. A following word load at 0x0 completes normally.
